// File: rtl/vx_uop_expander.sv
// Micro-op expander: emits in_count uops per instruction with index/first/last tags, zero-latency bypass on the first uop.
// Optional synchronous flush port enabled by defining UOP_EXPANDER_FLUSH_EN.
module vx_uop_expander #(
    parameter  int DATAW    = 128,
    parameter  int MAX_UOPS = 8,
    localparam int CNTW     = $clog2(MAX_UOPS + 1),
    localparam int IDXW     = $clog2(MAX_UOPS)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef UOP_EXPANDER_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    input  logic [CNTW-1:0]  in_count,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    output logic [IDXW-1:0]  out_uop_idx,
    output logic             out_first,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic [CNTW-1:0]  r_cnt;
    logic [DATAW-1:0] r_data;

    logic [CNTW-1:0]  w_eff;
    logic             w_act_last;
    logic             w_flush;

`ifdef UOP_EXPANDER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Zero means one uop; oversize counts saturate at the expansion depth.
    always_comb begin
        w_eff = in_count;
        if (in_count == '0) begin
            w_eff = CNTW'(1);
        end else if (in_count > CNTW'(MAX_UOPS)) begin
            w_eff = CNTW'(MAX_UOPS);
        end
    end

    assign w_act_last = (CNTW'(r_idx) == (r_cnt - CNTW'(1)));
    assign busy       = (r_state == ACTIVE);

    always_comb begin
        out_valid   = 1'b0;
        in_ready    = 1'b0;
        out_data    = in_data;
        out_uop_idx = '0;
        out_first   = 1'b1;
        out_last    = (w_eff == CNTW'(1));
        if (r_state == ACTIVE) begin
            out_data    = r_data;
            out_uop_idx = r_idx;
            out_first   = 1'b0;
            out_last    = w_act_last;
        end
        if (!reset && !w_flush) begin
            if (r_state == IDLE) begin
                out_valid = in_valid;
                in_ready  = out_ready;
            end else begin
                out_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else if (w_flush) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Uop 0 already left via bypass, so the sequence resumes at index 1.
                    if (in_valid && out_ready && (w_eff > CNTW'(1))) begin
                        r_data  <= in_data;
                        r_cnt   <= w_eff;
                        r_idx   <= IDXW'(1);
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (out_ready) begin
                        if (w_act_last) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_uop_expander.sv
// Self-checking bench for vx_uop_expander: vector table plus hand sequences, scoreboard of expected uops.
module tb_vx_uop_expander;

    localparam int DATAW    = 128;
    localparam int MAX_UOPS = 8;
    localparam int CNTW     = 4;
    localparam int IDXW     = 3;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic [CNTW-1:0]  in_count;
    logic             in_ready;
    logic             out_valid;
    logic [DATAW-1:0] out_data;
    logic [IDXW-1:0]  out_uop_idx;
    logic             out_first;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;

    vx_uop_expander #(
        .DATAW   (DATAW),
        .MAX_UOPS(MAX_UOPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef UOP_EXPANDER_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_count   (in_count),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_uop_idx(out_uop_idx),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATAW-1:0] data;
        logic [IDXW-1:0]  idx;
        logic             first;
        logic             last;
    } exp_uop_t;

    typedef struct {
        logic [CNTW-1:0]  cnt;
        logic [DATAW-1:0] data;
    } instr_t;

    typedef struct {
        logic [CNTW-1:0]  cnt;
        logic [DATAW-1:0] data;
        logic [31:0]      stall;
        int               exp_n;
        int               exp_cyc;
    } vec_t;

    exp_uop_t sb[$];
    instr_t   pend[$];

    task automatic chk(input string name, input logic [DATAW+15:0] act, input logic [DATAW+15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_instr(input logic [CNTW-1:0] cnt, input logic [DATAW-1:0] data, input int n);
        exp_uop_t u;
        pend.push_back('{cnt, data});
        for (int i = 0; i < n; i++) begin
            u.data  = data;
            u.idx   = IDXW'(i);
            u.first = (i == 0);
            u.last  = (i == n - 1);
            sb.push_back(u);
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic step(input logic ordy);
        logic exp_valid;
        logic exp_busy;
        logic exp_rdy;
        in_valid  = (pend.size() != 0);
        in_data   = (pend.size() != 0) ? pend[0].data : '0;
        in_count  = (pend.size() != 0) ? pend[0].cnt : '0;
        out_ready = ordy;
        @(negedge clk);
        exp_valid = (sb.size() != 0);
        exp_busy  = exp_valid && !sb[0].first;
        exp_rdy   = ordy && (!exp_valid || sb[0].first);
        chk("out_valid", DATAW'(out_valid), DATAW'(exp_valid));
        chk("busy", DATAW'(busy), DATAW'(exp_busy));
        chk("in_ready", DATAW'(in_ready), DATAW'(exp_rdy));
        if (exp_valid && out_valid) begin
            chk("uop", {out_data, out_uop_idx, out_first, out_last},
                {sb[0].data, sb[0].idx, sb[0].first, sb[0].last});
            if (out_ready) void'(sb.pop_front());
        end
        if (in_valid && in_ready && pend.size() != 0) void'(pend.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic [31:0] stall, input int limit, output int ncyc);
        ncyc = 0;
        while (sb.size() != 0 && ncyc < limit) begin
            step(!stall[ncyc % 32]);
            ncyc++;
        end
    endtask

    vec_t vecs[8];
    int   ncyc;

    initial begin
        vecs[0] = '{4'd1,  128'hA5,                 32'b0,    1, 1};
        vecs[1] = '{4'd4,  128'h11,                 32'b0,    4, 4};
        vecs[2] = '{4'd0,  128'h3C,                 32'b0,    1, 1};
        vecs[3] = '{4'd15, 128'hDEAD_BEEF_0000_0077, 32'b0,   8, 8};
        vecs[4] = '{4'd8,  128'h88,                 32'b0,    8, 8};
        vecs[5] = '{4'd3,  128'h5A,                 32'b1110, 3, 6};
        vecs[6] = '{4'd2,  128'hC3,                 32'b1,    2, 3};
        vecs[7] = '{4'd9,  128'h99,                 32'b1010, 8, 10};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h42;
        in_count  = 4'd1;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", DATAW'(in_ready), '0);
        chk("rst_out_valid", DATAW'(out_valid), '0);
        chk("rst_busy", DATAW'(busy), '0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        step(1'b1);

        for (int v = 0; v < 8; v++) begin
            push_instr(vecs[v].cnt, vecs[v].data, vecs[v].exp_n);
            drain(vecs[v].stall, 40, ncyc);
            chk($sformatf("vec%0d_cycles", v), DATAW'(ncyc), DATAW'(vecs[v].exp_cyc));
            chk($sformatf("vec%0d_drained", v), DATAW'(sb.size()), '0);
        end

        // Back-to-back A(3) then B(2): five fires in five cycles.
        push_instr(4'd3, 128'hAAAA, 3);
        push_instr(4'd2, 128'hBBBB, 2);
        drain(32'b0, 40, ncyc);
        chk("b2b_cycles", DATAW'(ncyc), DATAW'(5));
        chk("b2b_drained", DATAW'(sb.size()), '0);
        step(1'b1);

        // Async reset at idx 2 of 4 takes effect without a clock edge.
        push_instr(4'd4, 128'hD4, 4);
        step(1'b1);
        step(1'b1);
        chk("pre_rst_busy", DATAW'(busy), DATAW'(1));
        chk("pre_rst_idx", DATAW'(out_uop_idx), DATAW'(2));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", DATAW'(busy), '0);
        chk("mid_rst_out_valid", DATAW'(out_valid), '0);
        sb.delete();
        pend.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1);
        push_instr(4'd2, 128'hE2, 2);
        drain(32'b0, 40, ncyc);
        chk("post_rst_cycles", DATAW'(ncyc), DATAW'(2));

`ifdef UOP_EXPANDER_FLUSH_EN
        // Flush at idx 1 of 4 abandons the sequence; next instruction bypasses immediately.
        push_instr(4'd4, 128'hF1, 4);
        step(1'b1);
        flush     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", DATAW'(out_valid), '0);
        chk("flush_in_ready", DATAW'(in_ready), '0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb.delete();
        pend.delete();
        push_instr(4'd1, 128'hB2, 1);
        drain(32'b0, 40, ncyc);
        chk("post_flush_cycles", DATAW'(ncyc), DATAW'(1));
`endif

        step(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
